top_syncfifo_rd: RTL and testbench
==================================

// Module: top_syncFIFO_rd
// PURPOSE
//  ASIC-side receive path: FPGA pushes 32b words to the chip over the SPI-style pad bus
//  (O_spi_sck / I_spi_data / O_spi_cs_n). It is the read-direction counterpart of the OFM write path.
//  Pad signals are oversampled in the single clk_chip domain, synchronised and edge-detected,
//  then buffered in a small synchronous FIFO. The core drains the FIFO through a valid/ready port.
//  Each transfer is opened by an ASIC config pulse and a config_req / cmd handshake to the FPGA.
// PARAMETERS
//  SPI_WIDTH        32    pad data width = FIFO word width
//  ADDR_WIDTH_FIFO  3     FIFO depth = 2**ADDR_WIDTH_FIFO (8)
//  TX_WIDTH         20    width of the received-word counter
//  RD_COUNT         64    words per transfer (must be >=1 and < 2**TX_WIDTH)
// PORTS
//  clk_chip      in   1      single clock; all pad inputs are asynchronous to it
//  reset_chip    in   1      synchronous, active-high reset
//  O_spi_sck     in   1      FPGA serial clock (pad); sampled, never used as a clock
//  I_spi_data    in   SPI_WIDTH  FPGA data (pad); held stable for one full sck period
//  O_spi_cs_n    in   1      FPGA frame select, active low (pad)
//  config_req    out  1      to FPGA: transfer requested
//  config_cmd    out  4      to FPGA: latched command nibble
//  spi_hold      out  1      to FPGA: FIFO occupancy >= depth-2; FPGA pauses sck
//  config_ready  out  1      to core: block is in IDLE
//  config_paulse in   1      from core: one-cycle start pulse
//  config_data   in   4      from core: command, sampled with config_paulse
//  rd_valid      out  1      FIFO not empty
//  rd_data       out  SPI_WIDTH  FIFO head word (show-ahead)
//  rd_ready      in   1      core pops when rd_valid && rd_ready
//  rd_done       out  1      one-cycle pulse at DONE->IDLE
//  rd_overflow   out  1      sticky: a word was dropped; cleared on CONFIG
// BEHAVIOUR
//  Reset: state=IDLE. Outputs config_req=0, config_cmd=0, spi_hold=0, rd_valid=0, rd_done=0,
//   rd_overflow=0. FIFO pointers and word count are 0. Pad syncs preset to sck=0, cs_n=1.
//  Sync: sck, cs_n and data each pass 2 flops (same depth, aligned). An sck rising edge is
//   sck_s & ~sck_s_d. Pad sck edge -> FIFO write occurs 3 clk later; write -> rd_valid +1 clk.
//  Rule: pad sck high and low phases must each last >= 3 clk_chip.
//  FSM:
//   IDLE:    config_paulse -> CONFIG, config_cmd <= config_data.
//   CONFIG:  1 cycle; config_req <= 1; word count, rd_overflow and checksum clear -> WAIT.
//   WAIT:    cs_n_s == 0 -> RD_DATA, config_req <= 0.
//   RD_DATA: write on each sck edge while cs_n_s == 0; count++ on each accepted write.
//            Exit to DONE when count reaches RD_COUNT, or on cs_n_s rising (short frame).
//            Edges after count == RD_COUNT are ignored.
//   DONE:    wait for FIFO empty, then pulse rd_done -> IDLE.
//  config_paulse outside IDLE is ignored.
//  FIFO:
//   - A write is accepted if not full, or if a pop happens in the same cycle.
//   - Otherwise the word is dropped, rd_overflow is set and count is not incremented.
//   - Pop on an empty FIFO does nothing. Pointers wrap modulo depth.
//   - Full/empty are tracked with an extra pointer MSB.
//  spi_hold is registered: 1 when occupancy >= 2**ADDR_WIDTH_FIFO - 2.
//  Reset mid-transfer: everything returns to reset values next cycle; FIFO contents are discarded.
// CONFIGURATION
//  RD_CHECKSUM_EN defined:
//   - Adds output rd_checksum [SPI_WIDTH-1:0]: sum mod 2**SPI_WIDTH of accepted words.
//   - Cleared in CONFIG; holds its final value from DONE until the next CONFIG.
//  RD_CHECKSUM_EN undefined: the port and adder do not exist; all other behaviour is identical.
// TESTING
//  1 Nominal: pulse cmd=4'hA; FPGA sends 64 words 0..63 at sck = 8 clk/period, rd_ready=1
//    -> config_req rises 1 clk after CONFIG; rd_data 0..63 in order; rd_done once; overflow=0.
//  2 Backpressure: rd_ready=0 and FPGA obeys spi_hold -> spi_hold=1 at occupancy 6;
//    release rd_ready -> all 64 words delivered, no drop.
//  3 Overflow: rd_ready=0 and FPGA ignores spi_hold, sends 10 words
//    -> FIFO holds words 0..7; rd_overflow=1; count=8.
//  4 Short frame: cs_n rises after 5 words -> DONE; 5 words delivered, then rd_done.
//  5 Reset mid RD_DATA after 20 words -> next clk state=IDLE, rd_valid=0, config_req=0.
//  6 RD_CHECKSUM_EN: words 1..64 -> rd_checksum = 32'd2080 at rd_done.

Source files
------------

// File: rtl/top_syncfifo_rd.sv
// Pad-bus receive path: oversample and synchronise the SPI-style pad bus, buffer words in a small
// synchronous FIFO and drain them to the core. Optional feature macro: RD_CHECKSUM_EN (adds rd_checksum).
module top_syncfifo_rd #(
    parameter int SPI_WIDTH       = 32,
    parameter int ADDR_WIDTH_FIFO = 3,
    parameter int TX_WIDTH        = 20,
    parameter int RD_COUNT        = 64
) (
    input  logic                 clk_chip,
    input  logic                 reset_chip,
    input  logic                 O_spi_sck,
    input  logic [SPI_WIDTH-1:0] I_spi_data,
    input  logic                 O_spi_cs_n,
    output logic                 config_req,
    output logic [3:0]           config_cmd,
    output logic                 spi_hold,
    output logic                 config_ready,
    input  logic                 config_paulse,
    input  logic [3:0]           config_data,
    output logic                 rd_valid,
    output logic [SPI_WIDTH-1:0] rd_data,
    input  logic                 rd_ready,
    output logic                 rd_done,
    output logic                 rd_overflow,
`ifdef RD_CHECKSUM_EN
    output logic [SPI_WIDTH-1:0] rd_checksum,
`endif
    output logic [2:0]           dbg_state
);
    localparam int DEPTH = 1 << ADDR_WIDTH_FIFO;
    localparam int PW    = ADDR_WIDTH_FIFO + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_CONFIG, ST_WAIT, ST_RD_DATA, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic                  sck_meta_q, sck_sync_q, sck_prev_q;
    logic                  cs_meta_q, cs_sync_q, cs_prev_q;
    logic [SPI_WIDTH-1:0]  data_meta_q, data_sync_q;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ_d;
    logic [SPI_WIDTH-1:0]  mem_q [DEPTH];
    logic [TX_WIDTH-1:0]   count_q, count_d;
    logic [3:0]            cmd_q, cmd_d;
    logic                  req_q, req_d, hold_q, hold_d, done_q, done_d, ovf_q, ovf_d;
    logic                  sck_rise, cs_rise, empty, full, pop, wr_req, wr_acc;

    // Data is synchronised with the same depth as sck so the word sampled at a detected edge is the
    // one the FPGA held around that edge.
    always_ff @(posedge clk_chip) begin
        if (reset_chip) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            data_meta_q <= '0;
            data_sync_q <= '0;
        end else begin
            sck_meta_q  <= O_spi_sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            cs_meta_q   <= O_spi_cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            data_meta_q <= I_spi_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign sck_rise = sck_sync_q & ~sck_prev_q;
    assign cs_rise  = cs_sync_q & ~cs_prev_q;

    // Core port: a word transfers on any cycle where rd_valid && rd_ready; rd_data is the FIFO head
    // and stays stable while rd_valid is high and rd_ready is low.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign pop    = rd_ready && !empty;
    assign wr_req = (state_q == ST_RD_DATA) && sck_rise && !cs_sync_q &&
                    (count_q < TX_WIDTH'(RD_COUNT));
    assign wr_acc = wr_req && (!full || pop);

    assign wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);
    assign occ_d    = wr_ptr_d - rd_ptr_d;
    assign hold_d   = (occ_d >= PW'(DEPTH - 2));

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        req_d   = req_q;
        done_d  = 1'b0;
        count_d = count_q + TX_WIDTH'(wr_acc);
        ovf_d   = ovf_q | (wr_req && !wr_acc);
        case (state_q)
            ST_IDLE: begin
                if (config_paulse) begin
                    state_d = ST_CONFIG;
                    cmd_d   = config_data;
                end
            end
            ST_CONFIG: begin
                req_d   = 1'b1;
                count_d = '0;
                ovf_d   = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!cs_sync_q) begin
                    req_d   = 1'b0;
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if ((count_q == TX_WIDTH'(RD_COUNT)) || cs_rise) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_chip) begin
        if (reset_chip) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cmd_q    <= '0;
            req_q    <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cmd_q    <= cmd_d;
            req_q    <= req_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_chip) begin
        if (wr_acc) mem_q[wr_ptr_q[PW-2:0]] <= data_sync_q;
    end

`ifdef RD_CHECKSUM_EN
    logic [SPI_WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == ST_CONFIG) csum_d = '0;
        else if (wr_acc)          csum_d = csum_q + data_sync_q;
    end

    always_ff @(posedge clk_chip) begin
        if (reset_chip) csum_q <= '0;
        else            csum_q <= csum_d;
    end

    assign rd_checksum = csum_q;
`endif

    assign config_req   = req_q;
    assign config_cmd   = cmd_q;
    assign spi_hold     = hold_q;
    assign config_ready = (state_q == ST_IDLE);
    assign rd_valid     = !empty;
    assign rd_data      = mem_q[rd_ptr_q[PW-2:0]];
    assign rd_done      = done_q;
    assign rd_overflow  = ovf_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_top_syncfifo_rd.sv
// Bench for top_syncfifo_rd: table of transfers plus hand-written overflow and mid-transfer reset
// sequences; a scoreboard queue holds the words the core port must deliver, in order.
module tb_top_syncfifo_rd;
    localparam logic [2:0] S_IDLE = 3'd0, S_CONFIG = 3'd1, S_WAIT = 3'd2, S_RD = 3'd3;

    logic        clk_chip = 1'b0;
    logic        reset_chip = 1'b1;
    logic        O_spi_sck = 1'b0;
    logic [31:0] I_spi_data = '0;
    logic        O_spi_cs_n = 1'b1;
    logic        config_req, config_ready, spi_hold, rd_valid, rd_done, rd_overflow;
    logic [3:0]  config_cmd;
    logic        config_paulse = 1'b0;
    logic [3:0]  config_data = '0;
    logic [31:0] rd_data;
    logic        rd_ready = 1'b1;
    logic [2:0]  dbg_state;
`ifdef RD_CHECKSUM_EN
    logic [31:0] rd_checksum;
`endif

    top_syncfifo_rd dut (
        .clk_chip(clk_chip), .reset_chip(reset_chip),
        .O_spi_sck(O_spi_sck), .I_spi_data(I_spi_data), .O_spi_cs_n(O_spi_cs_n),
        .config_req(config_req), .config_cmd(config_cmd), .spi_hold(spi_hold),
        .config_ready(config_ready), .config_paulse(config_paulse), .config_data(config_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .rd_done(rd_done), .rd_overflow(rd_overflow),
`ifdef RD_CHECKSUM_EN
        .rd_checksum(rd_checksum),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk_chip = ~clk_chip;

    typedef struct {
        logic [3:0]  cmd;
        int          n_words;
        int          extra;       // edges sent after the frame is complete; must be ignored
        logic [31:0] base;
        logic [31:0] stride;      // 0 selects random data
        int          ready_mode;  // 0 always ready, 1 stalled until spi_hold, 2 random
        int          exp_hold_at; // words sent when spi_hold first rises (mode 1)
        bit          exp_ovf;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_sum;
    int          done_cnt;
    int          sent_cnt;
    bit          sending;
    vec_t        vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_chip);
        #1;
    endtask

    // Scoreboard: every pop on the core port must match the oldest expected word.
    always @(negedge clk_chip) begin
        if (!reset_chip) begin
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: actual=%0h required=none", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
            if (rd_done) done_cnt++;
        end
    end

    task automatic send_word(input logic [31:0] data, input bit obey, input bit push);
        int guard;
        I_spi_data = data;
        O_spi_sck  = 1'b0;
        wait_clk(4);
        guard = 0;
        while (obey && spi_hold && guard < 3000) begin
            wait_clk(1);
            guard++;
        end
        if (guard >= 3000) check("hold_timeout", 1, 0);
        if (push) begin
            exp_q.push_back(data);
            exp_sum += data;
        end
        O_spi_sck = 1'b1;
        sent_cnt++;
        wait_clk(4);
        O_spi_sck = 1'b0;
    endtask

    task automatic do_config(input logic [3:0] cmd);
        int guard = 0;
        while (!config_ready && guard < 3000) begin
            wait_clk(1);
            guard++;
        end
        check("config_ready", config_ready, 1);
        config_data   = cmd;
        config_paulse = 1'b1;
        wait_clk(1);
        config_paulse = 1'b0;
        @(negedge clk_chip);
        check("state_config", dbg_state, S_CONFIG);
        check("req_in_config", config_req, 0);
        check("config_cmd", config_cmd, cmd);
        wait_clk(1);
        @(negedge clk_chip);
        check("config_req_rise", config_req, 1);
        check("state_wait", dbg_state, S_WAIT);
        check("ovf_cleared", rd_overflow, 0);
        config_data   = ~cmd;
        config_paulse = 1'b1;
        wait_clk(1);
        config_paulse = 1'b0;
        @(negedge clk_chip);
        check("pulse_ignored_cmd", config_cmd, cmd);
        check("pulse_ignored_state", dbg_state, S_WAIT);
        exp_sum  = '0;
        done_cnt = 0;
        sent_cnt = 0;
    endtask

    task automatic open_frame();
        O_spi_cs_n = 1'b0;
        wait_clk(4);
        @(negedge clk_chip);
        check("state_rd_data", dbg_state, S_RD);
        check("req_dropped", config_req, 0);
        wait_clk(1);
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_cnt == 0 && guard < 3000) begin
            wait_clk(1);
            guard++;
        end
        wait_clk(3);
        check("rd_done_once", done_cnt, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        check("idle_after_done", dbg_state, S_IDLE);
        check("rd_valid_after_done", rd_valid, 0);
    endtask

    task automatic run_vector(input vec_t v);
        logic [31:0] w;
        rd_ready = (v.ready_mode == 1) ? 1'b0 : 1'b1;
        do_config(v.cmd);
        open_frame();
        sending = 1'b1;
        fork
            begin
                for (int i = 0; i < v.n_words + v.extra; i++) begin
                    w = (v.stride == 0) ? $urandom : v.base + v.stride * i;
                    send_word(w, 1'b1, i < v.n_words);
                end
                sending = 1'b0;
            end
            begin
                if (v.ready_mode == 1) begin
                    int guard = 0;
                    while (!spi_hold && guard < 3000) begin
                        wait_clk(1);
                        guard++;
                    end
                    check("hold_at_occupancy", sent_cnt, v.exp_hold_at);
                    wait_clk(30);
                    check("sender_paused", sent_cnt, v.exp_hold_at);
                    check("no_drop_while_held", rd_overflow, 0);
                    rd_ready = 1'b1;
                end else if (v.ready_mode == 2) begin
                    while (sending) begin
                        rd_ready = 1'($urandom_range(0, 1));
                        wait_clk(1);
                    end
                    rd_ready = 1'b1;
                end
            end
        join
        wait_clk(2);
        O_spi_cs_n = 1'b1;
        wait_done();
        check("rd_overflow", rd_overflow, v.exp_ovf);
`ifdef RD_CHECKSUM_EN
        check("rd_checksum", rd_checksum, exp_sum);
        if (v.base == 32'd1 && v.stride == 32'd1 && v.n_words == 64)
            check("rd_checksum_1_64", rd_checksum, 32'd2080);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{cmd: 4'hA, n_words: 64, extra: 2, base: 32'd0, stride: 32'd1,
                    ready_mode: 0, exp_hold_at: 0, exp_ovf: 1'b0};
        vecs[1] = '{cmd: 4'h5, n_words: 64, extra: 0, base: 32'd1, stride: 32'd1,
                    ready_mode: 1, exp_hold_at: 6, exp_ovf: 1'b0};
        vecs[2] = '{cmd: 4'h3, n_words: 5, extra: 0, base: 32'hDEAD_0000, stride: 32'h1111,
                    ready_mode: 0, exp_hold_at: 0, exp_ovf: 1'b0};
        vecs[3] = '{cmd: 4'hF, n_words: 64, extra: 0, base: 32'hFFFF_FFF0, stride: 32'h0100_0001,
                    ready_mode: 2, exp_hold_at: 0, exp_ovf: 1'b0};
        vecs[4] = '{cmd: 4'h6, n_words: 64, extra: 0, base: 32'd0, stride: 32'd0,
                    ready_mode: 2, exp_hold_at: 0, exp_ovf: 1'b0};
        done_cnt = 0;
        sent_cnt = 0;
        exp_sum  = '0;
        sending  = 1'b0;

        wait_clk(3);
        @(negedge clk_chip);
        check("rst_state", dbg_state, S_IDLE);
        check("rst_config_req", config_req, 0);
        check("rst_config_cmd", config_cmd, 0);
        check("rst_spi_hold", spi_hold, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_rd_overflow", rd_overflow, 0);
        check("rst_config_ready", config_ready, 1);
        wait_clk(1);
        reset_chip = 1'b0;
        wait_clk(2);

        for (int i = 0; i < 5; i++) run_vector(vecs[i]);

        // Overflow: FPGA ignores spi_hold with the core stalled; only the first 8 words fit.
        rd_ready = 1'b0;
        do_config(4'h7);
        open_frame();
        for (int i = 0; i < 10; i++) send_word(32'h0000_0100 + i, 1'b0, i < 8);
        wait_clk(2);
        @(negedge clk_chip);
        check("ovf_set", rd_overflow, 1);
        check("ovf_hold", spi_hold, 1);
        check("ovf_still_rd_data", dbg_state, S_RD);
        wait_clk(1);
        rd_ready = 1'b1;
        wait_clk(20);
        @(negedge clk_chip);
        check("ovf_sticky", rd_overflow, 1);
        check("ovf_drained", exp_q.size(), 0);
        check("ovf_hold_released", spi_hold, 0);
        wait_clk(1);
        O_spi_cs_n = 1'b1;
        wait_done();

        // Reset in the middle of a frame with words still buffered.
        do_config(4'h9);
        open_frame();
        for (int i = 0; i < 20; i++) send_word(32'h5000 + i, 1'b1, 1'b1);
        rd_ready = 1'b0;
        for (int i = 0; i < 2; i++) send_word(32'h6000 + i, 1'b1, 1'b1);
        @(negedge clk_chip);
        check("pre_reset_valid", rd_valid, 1);
        wait_clk(1);
        reset_chip = 1'b1;
        wait_clk(1);
        @(negedge clk_chip);
        check("mid_rst_state", dbg_state, S_IDLE);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_config_req", config_req, 0);
        check("mid_rst_config_cmd", config_cmd, 0);
        check("mid_rst_spi_hold", spi_hold, 0);
        exp_q.delete();
        wait_clk(1);
        O_spi_cs_n = 1'b1;
        rd_ready   = 1'b1;
        reset_chip = 1'b0;
        wait_clk(3);

        run_vector(vecs[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
